// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared constants for the multi-cycle RV32I control path:
//   - supported major opcodes (R, I-ALU, load, store, branch)
//   - FSM state encoding (4-bit, exported on state_o for debug)
//   - ALUOp codes and ALU operand-select codes
// Optional feature macro: ILLEGAL_TRAP_EN (adds the TRAP state).
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_BRANCH   = 4'd10
`ifdef ILLEGAL_TRAP_EN
    ,
    S_TRAP     = 4'd11
`endif
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_opcode_class_decode.sv
// ---------------------------------------------------------------------------
// opcode_class_decode
// Classifies the IR opcode field into exactly one instruction class.
// Ports:
//   i_opcode   in  7  IR[6:0]
//   o_r        out 1  R-type ALU
//   o_i        out 1  I-type ALU
//   o_load     out 1  load
//   o_store    out 1  store
//   o_branch   out 1  conditional branch
//   o_illegal  out 1  anything else
// ---------------------------------------------------------------------------
module opcode_class_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_r,
  output logic       o_i,
  output logic       o_load,
  output logic       o_store,
  output logic       o_branch,
  output logic       o_illegal
);

  always_comb begin
    o_r       = 1'b0;
    o_i       = 1'b0;
    o_load    = 1'b0;
    o_store   = 1'b0;
    o_branch  = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_R:      o_r      = 1'b1;
      OPC_I:      o_i      = 1'b1;
      OPC_LOAD:   o_load   = 1'b1;
      OPC_STORE:  o_store  = 1'b1;
      OPC_BRANCH: o_branch = 1'b1;
      default:    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing a multi-cycle RV32I datapath (fetch, decode, execute,
// memory, writeback) for R, I-ALU, load, store and branch instructions.
// Memory-completion enables are additionally gated by mem_ready; a wait
// counter abandons an access after WAIT_LIMIT cycles (0 = never).
// Optional feature macro: ILLEGAL_TRAP_EN -- unsupported opcodes park the FSM
// in TRAP (illegal_instr=1) until reset; otherwise they retire nothing and
// the FSM returns to FETCH.
// Ports:
//   clk, rst_n (async active-low)
//   opcode[6:0], zero, mem_ready                       inputs
//   mem_req, mem_we, iord, ir_write, pc_write, pc_src  memory / PC control
//   alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]        ALU control
//   reg_write, mem_to_reg                              register writeback
//   instr_retired, mem_timeout, illegal_instr          status pulses/flags
//   state_o[3:0]                                       debug state
// ---------------------------------------------------------------------------
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_retired,
  output logic       mem_timeout,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  localparam bit              TIMEOUT_EN = (WAIT_LIMIT > 0);
  localparam logic [CNT_W-1:0] LIMIT_M1  = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_DEST = S_TRAP;
`else
  localparam state_t ILLEGAL_DEST = S_FETCH;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch, w_illegal;
  logic w_in_mem;
  logic w_timeout;

  opcode_class_decode u_decode (
    .i_opcode  (opcode),
    .o_r       (w_is_r),
    .o_i       (w_is_i),
    .o_load    (w_is_load),
    .o_store   (w_is_store),
    .o_branch  (w_is_branch),
    .o_illegal (w_illegal)
  );

  assign w_in_mem  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // mem_ready in the last allowed wait cycle wins over the timeout.
  assign w_timeout = TIMEOUT_EN && w_in_mem && !mem_ready && (r_wait_cnt == LIMIT_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Any state outside an access, a completion or a timeout leaves the
      // counter at zero, so every access (including a retried fetch) starts fresh.
      if (!w_in_mem || mem_ready || w_timeout)
        r_wait_cnt <= '0;
      else
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_retired = 1'b0;
    mem_timeout   = 1'b0;
    illegal_instr = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          mem_timeout = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_b = SRCB_IMM;
        if (w_is_load || w_is_store) w_next = S_MEM_ADDR;
        else if (w_is_r)             w_next = S_EXEC_R;
        else if (w_is_i)             w_next = S_EXEC_I;
        else if (w_is_branch)        w_next = S_BRANCH;
        else if (w_illegal)          w_next = ILLEGAL_DEST;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = w_is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          w_next = S_WB_MEM;
        end else if (w_timeout) begin
          mem_timeout = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        instr_retired = 1'b1;
        w_next        = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          w_next        = S_FETCH;
        end else if (w_timeout) begin
          mem_timeout = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_RTYPE;
        w_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ITYPE;
        w_next    = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        w_next        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_SUB;
        pc_src        = 1'b1;
        pc_write      = zero;
        instr_retired = 1'b1;
        w_next        = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_instr = 1'b1;
        w_next        = S_TRAP;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  localparam int LIM = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, instr_retired, mem_timeout, illegal_instr;
  logic [3:0] state_o;

  multicycle_control #(.WAIT_LIMIT(LIM), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .instr_retired(instr_retired), .mem_timeout(mem_timeout),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                alu_op, reg_write, mem_to_reg, instr_retired, mem_timeout, illegal_instr};

  localparam logic [16:0] B_REQ  = 17'd1 << 16;
  localparam logic [16:0] B_WE   = 17'd1 << 15;
  localparam logic [16:0] B_IORD = 17'd1 << 14;
  localparam logic [16:0] B_IRW  = 17'd1 << 13;
  localparam logic [16:0] B_PCW  = 17'd1 << 12;
  localparam logic [16:0] B_PCS  = 17'd1 << 11;
  localparam logic [16:0] B_RW   = 17'd1 << 4;
  localparam logic [16:0] B_M2R  = 17'd1 << 3;
  localparam logic [16:0] B_RET  = 17'd1 << 2;
  localparam logic [16:0] B_TMO  = 17'd1 << 1;
  localparam logic [16:0] B_ILL  = 17'd1;

  typedef struct packed {
    logic        rdy;
    logic        z;
    logic [6:0]  opc;
    logic [3:0]  st;
    logic [16:0] o;
  } cyc_t;

  cyc_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [16:0] ab(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    return {6'b0, a, b, op, 5'b0};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic rdy, input logic z, input logic [6:0] opc,
                               input state_t st, input logic [16:0] o);
    cyc_t e;
    e.rdy = rdy; e.z = z; e.opc = opc; e.st = st; e.o = o;
    q.push_back(e);
  endfunction

  // One memory access: 'lat' not-ready cycles then ready, unless the access is
  // abandoned on the LIM-th waiting cycle. Returns 1 when the access completes.
  function automatic bit mem_phase(input state_t st, input logic [6:0] opc, input logic z,
                                   input logic [16:0] wait_o, input logic [16:0] done_o, input int lat);
    for (int k = 0; k < 64; k++) begin
      if (k == lat) begin
        push(1'b1, z, opc, st, done_o);
        return 1'b1;
      end
      if (LIM > 0 && k == LIM - 1) begin
        push(1'b0, z, opc, st, wait_o | B_TMO);
        return 1'b0;
      end
      push(1'b0, z, opc, st, wait_o);
    end
    return 1'b0;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction starting in FETCH.
  function automatic void build(input logic [6:0] opc, input logic z, input int flat, input int mlat);
    logic [16:0] f;
    f = B_REQ | ab(SRCA_PC, SRCB_FOUR, ALUOP_ADD);
    if (!mem_phase(S_FETCH, opc, z, f, f | B_IRW | B_PCW, flat)) return;
    push(rnd(), z, opc, S_DECODE, ab(SRCA_PC, SRCB_IMM, ALUOP_ADD));
    case (opc)
      OPC_LOAD: begin
        push(rnd(), z, opc, S_MEM_ADDR, ab(SRCA_RS1, SRCB_IMM, ALUOP_ADD));
        if (mem_phase(S_MEM_RD, opc, z, B_REQ | B_IORD, B_REQ | B_IORD, mlat))
          push(rnd(), z, opc, S_WB_MEM, B_RW | B_M2R | B_RET);
      end
      OPC_STORE: begin
        push(rnd(), z, opc, S_MEM_ADDR, ab(SRCA_RS1, SRCB_IMM, ALUOP_ADD));
        void'(mem_phase(S_MEM_WR, opc, z, B_REQ | B_WE | B_IORD, B_REQ | B_WE | B_IORD | B_RET, mlat));
      end
      OPC_R: begin
        push(rnd(), z, opc, S_EXEC_R, ab(SRCA_RS1, SRCB_RS2, ALUOP_RTYPE));
        push(rnd(), z, opc, S_WB_ALU, B_RW | B_RET);
      end
      OPC_I: begin
        push(rnd(), z, opc, S_EXEC_I, ab(SRCA_RS1, SRCB_IMM, ALUOP_ITYPE));
        push(rnd(), z, opc, S_WB_ALU, B_RW | B_RET);
      end
      OPC_BRANCH:
        push(rnd(), z, opc, S_BRANCH,
             ab(SRCA_RS1, SRCB_RS2, ALUOP_SUB) | B_PCS | B_RET | (z ? B_PCW : 17'd0));
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) push(rnd(), z, opc, S_TRAP, B_ILL);
`endif
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic play(input string tag);
    cyc_t e;
    int n;
    n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk); #1;
      mem_ready = e.rdy; zero = e.z; opcode = e.opc;
      #1;
      chk($sformatf("%s c%0d state", tag, n), 32'(state_o), 32'(e.st));
      chk($sformatf("%s c%0d outs", tag, n), 32'(obs), 32'(e.o));
      n++;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " state"}, 32'(state_o), 32'(S_IDLE));
    chk({tag, " outs"}, 32'(obs), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b0;
    #1 check_idle("rst_assert");
    @(posedge clk); #1;
    check_idle("rst_hold");
    rst_n = 1'b1;
    #1 check_idle("rst_release");
  endtask

  function automatic logic [6:0] pick_opc(input int cls);
    logic [6:0] bad [5];
    bad[0] = 7'b1111111; bad[1] = 7'b0110111; bad[2] = 7'b0010111;
    bad[3] = 7'b1101111; bad[4] = 7'b0000000;
    case (cls)
      0: return OPC_R;
      1: return OPC_I;
      2: return OPC_LOAD;
      3: return OPC_STORE;
      4: return OPC_BRANCH;
      default: return bad[$urandom_range(0, 4)];
    endcase
  endfunction

  function automatic int pick_lat();
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(LIM, LIM + 2));
    return int'($urandom_range(0, LIM - 1));
  endfunction

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
    #3 check_idle("por");
    do_reset();

    build(OPC_R, 1'b0, 0, 0);          play("r_type");
    build(OPC_LOAD, 1'b0, 0, 2);       play("load_late2");
    build(OPC_BRANCH, 1'b1, 0, 0);     play("beq_taken");
    build(OPC_BRANCH, 1'b0, 0, 0);     play("beq_not");
    build(OPC_STORE, 1'b0, 0, LIM + 2); play("store_tmo");
    build(OPC_I, 1'b0, LIM - 1, 0);    play("fetch_ready_at_limit");
    build(OPC_STORE, 1'b0, 1, LIM - 1); play("store_ready_at_limit");
    build(OPC_R, 1'b0, LIM, 0);        play("fetch_tmo");
    build(OPC_I, 1'b1, 0, 0);          play("i_type");

    build(7'b1111111, 1'b0, 0, 0);     play("illegal");
`ifdef ILLEGAL_TRAP_EN
    do_reset();
`endif

    // Reset asserted while a load waits on memory.
    build(OPC_LOAD, 1'b0, 0, 20);
    q = q[0:4];
    play("rd_wait");
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1 chk("mid_access mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst state", 32'(state_o), 32'(S_IDLE));
    chk("async_rst mem_req", 32'(mem_req), 32'd0);
    do_reset();

    for (int i = 0; i < 60; i++) begin
      int cls;
      cls = int'($urandom_range(0, 5));
      build(pick_opc(cls), rnd(), pick_lat(), pick_lat());
      play($sformatf("rnd%0d", i));
`ifdef ILLEGAL_TRAP_EN
      if (cls == 5) do_reset();
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
